serial_add: RTL and testbench
=============================

SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 SHALL have parameter A_SIGNED, default 0: A operand is two's complement when 1.
REQ-002 SHALL have parameter B_SIGNED, default 0: B operand is two's complement when 1.
REQ-003 SHALL have parameter A_WIDTH, default 8: width of a.
REQ-004 SHALL have parameter B_WIDTH, default 8: width of b.
REQ-005 SHALL have parameter Y_WIDTH, default 9: width of result y.
REQ-006 SHALL have parameter CHUNK_WIDTH, default 4: adder slice width processed per cycle; must be >= 1.
REQ-007 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port in_valid, input, 1: operands a and b are valid.
REQ-010 SHALL have port in_ready, output, 1: block accepts operands.
REQ-011 SHALL have port a, input, A_WIDTH: first operand.
REQ-012 SHALL have port b, input, B_WIDTH: second operand.
REQ-013 SHALL have port out_valid, output, 1: y holds a completed sum.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts y.
REQ-015 SHALL have port y, output, Y_WIDTH: registered sum.

Function
REQ-016 SHALL define NCHUNK = ceil(Y_WIDTH/CHUNK_WIDTH) and PAD = NCHUNK*CHUNK_WIDTH.
REQ-017 SHALL treat both operands as signed only when A_SIGNED=1 and B_SIGNED=1; otherwise both are treated as unsigned.
REQ-018 SHALL, on accept, capture a and b extended (sign-extended if signed, zero-extended otherwise) or truncated to PAD bits.
REQ-019 SHALL implement states IDLE, RUN and DONE.
REQ-020 SHALL drive in_ready=1 only in IDLE.
REQ-021 Accept SHALL occur on an edge with in_valid=1 and in_ready=1, moving IDLE->RUN, clearing the chunk index k and the carry register.
REQ-022 In RUN, each edge SHALL add operand chunk k plus carry, write the CHUNK_WIDTH-bit sum to result chunk k, store carry-out, and increment k.
REQ-023 SHALL move RUN->DONE on the edge that processes chunk NCHUNK-1; out_valid becomes 1 exactly NCHUNK edges after the accept edge.
REQ-024 SHALL drive y = result[Y_WIDTH-1:0], i.e. the sum modulo 2^Y_WIDTH, with no overflow flag and the final carry discarded.
REQ-025 In DONE, SHALL hold out_valid=1 and y stable until an edge with out_ready=1, then move DONE->IDLE with out_valid=0.
REQ-026 SHALL ignore in_valid and operand changes while in RUN or DONE.
REQ-027 When NCHUNK=1, SHALL still take one RUN edge, giving latency 1.
REQ-028 Back-to-back throughput with out_ready=1 held high SHALL be one result per NCHUNK+2 cycles.
REQ-029 y SHALL retain the last result after DONE->IDLE until the next result is written.

Reset
REQ-030 Reset SHALL force state=IDLE, k=0, carry=0, result=0, out_valid=0, in_ready=1 and y=0.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation with no result delivered.
REQ-032 Reset SHALL take precedence over any simultaneous accept or output handshake on the same edge.

Verification
REQ-033 Defaults, unsigned: a=8'hFF, b=8'h01 accepted -> out_valid rises 3 edges later with y=9'h100.
REQ-034 A_SIGNED=B_SIGNED=1: a=8'hFF, b=8'h01 -> y=9'h000. Same operands with A_SIGNED=1, B_SIGNED=0 -> y=9'h100. Signed a=8'h80, b=8'hFF -> y=9'h17F.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> y and out_valid stay stable, in_ready stays 0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 Reset mid-RUN after 1 chunk -> next cycle state=IDLE, out_valid=0, y=0, in_ready=1; a following accept of 8'h10+8'h20 yields y=9'h030.
REQ-037 Y_WIDTH=4, CHUNK_WIDTH=8: a=8'hFF, b=8'h02 -> latency 1 edge, y=4'h1. Random back-to-back streams with out_ready=1 -> every y equals the reference sum modulo 2^Y_WIDTH at a period of NCHUNK+2.

Source files
------------

// File: rtl/serial_add.sv
// Bit-serial (chunk-serial) adder: operands are captured on accept and summed
// CHUNK_WIDTH bits per clock, with the result held until the consumer takes it.
module serial_add #(
  parameter int A_SIGNED    = 0,
  parameter int B_SIGNED    = 0,
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int Y_WIDTH     = 9,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] y
);

  localparam int NCHUNK = (Y_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int PAD    = NCHUNK * CHUNK_WIDTH;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam bit SIGNED_MODE = (A_SIGNED != 0) && (B_SIGNED != 0);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [KW-1:0]        k_q;
  logic                 carry_q;
  logic [PAD-1:0]       a_q;
  logic [PAD-1:0]       b_q;
  logic [PAD-1:0]       result_q;
  logic [PAD-1:0]       result_d;
  logic [Y_WIDTH-1:0]   y_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [PAD-1:0]         a_ext_s;
  logic [PAD-1:0]         b_ext_s;
  logic [CHUNK_WIDTH-1:0] a_chunk_s;
  logic [CHUNK_WIDTH-1:0] b_chunk_s;
  logic [CHUNK_WIDTH:0]   sum_s;

  // Extend or truncate the operands to the padded working width; mixed
  // signedness falls back to treating both as unsigned.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    if (SIGNED_MODE) begin
      a_ext_s = PAD'($signed(a));
      b_ext_s = PAD'($signed(b));
    end else begin
      a_ext_s = PAD'(a);
      b_ext_s = PAD'(b);
    end
  end

  // One chunk of the ripple sum, merged into the partial result.
  always_comb begin
    a_chunk_s = a_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    b_chunk_s = b_q[k_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK_WIDTH{1'b0}}, carry_q};
    result_d  = result_q;
    result_d[k_q*CHUNK_WIDTH +: CHUNK_WIDTH] = sum_s[CHUNK_WIDTH-1:0];
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= KW'(0);
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a_ext_s;
            b_q        <= b_ext_s;
            k_q        <= KW'(0);
            carry_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= sum_s[CHUNK_WIDTH];
          if (k_q == K_LAST) begin
            // y is only updated with a complete sum, so partial chunks never leak out.
            k_q         <= KW'(0);
            y_q         <= result_d[Y_WIDTH-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          k_q         <= KW'(0);
          carry_q     <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: directed vectors, handshake corner cases
// and randomized back-to-back streams across several parameterizations.
module tb_serial_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, out_ready;
  logic [7:0] a, b;
  logic       rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [8:0] y0, y1, y2;

  logic       in_valid3, out_ready3;
  logic [7:0] a3, b3;
  logic       rdy3, ov3;
  logic [3:0] y3;

  int n_cmp = 0;
  int n_bad = 0;

  // u: unsigned defaults, s: both signed, m: only A signed (treated unsigned)
  serial_add u_dut_u (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .y(y0));
  serial_add #(.A_SIGNED(1), .B_SIGNED(1)) u_dut_s (.clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b), .out_valid(ov1),
    .out_ready(out_ready), .y(y1));
  serial_add #(.A_SIGNED(1), .B_SIGNED(0)) u_dut_m (.clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy2), .a(a), .b(b), .out_valid(ov2),
    .out_ready(out_ready), .y(y2));
  serial_add #(.Y_WIDTH(4), .CHUNK_WIDTH(8)) u_dut_w (.clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(rdy3), .a(a3), .b(b3), .out_valid(ov3),
    .out_ready(out_ready3), .y(y3));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] eu;
    logic [8:0] es;
    logic [8:0] em;
  } vec_t;

  typedef struct {
    logic [8:0] eu;
    logic [8:0] es;
    logic [8:0] em;
  } exp_t;

  vec_t tbl[10];
  exp_t q012[$];
  logic [3:0] q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_int(input logic [7:0] x, input bit sgn);
    if (sgn) return int'($signed(x));
    return int'(x);
  endfunction

  function automatic logic [8:0] ref9(input logic [7:0] x, input logic [7:0] z, input bit sgn);
    return 9'(to_int(x, sgn) + to_int(z, sgn));
  endfunction

  function automatic logic [3:0] ref4(input logic [7:0] x, input logic [7:0] z);
    return 4'(to_int(x, 1'b0) + to_int(z, 1'b0));
  endfunction

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!ov0 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic op3(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] eu,
                     input logic [8:0] es, input logic [8:0] em, input string tag);
    chk({tag, " in_ready"}, rdy0, 1);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    chk({tag, " ov after accept"}, ov0, 0);
    wait_done(tag, 3);
    chk({tag, " y unsigned"}, y0, eu);
    chk({tag, " y signed"}, y1, es);
    chk({tag, " y mixed"}, y2, em);
    chk({tag, " ov signed"}, ov1, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " ov after take"}, ov0, 0);
    chk({tag, " ready after take"}, rdy0, 1);
    chk({tag, " y retained"}, y0, eu);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, last0, last3, nres0, nres3, lat;
    exp_t e;

    tbl[0] = '{8'hFF, 8'h01, 9'h100, 9'h000, 9'h100};
    tbl[1] = '{8'h80, 8'hFF, 9'h17F, 9'h17F, 9'h17F};
    tbl[2] = '{8'h10, 8'h20, 9'h030, 9'h030, 9'h030};
    tbl[3] = '{8'h7F, 8'h7F, 9'h0FE, 9'h0FE, 9'h0FE};
    tbl[4] = '{8'h00, 8'h00, 9'h000, 9'h000, 9'h000};
    tbl[5] = '{8'hFF, 8'hFF, 9'h1FE, 9'h1FE, 9'h1FE};
    tbl[6] = '{8'h80, 8'h80, 9'h100, 9'h100, 9'h100};
    tbl[7] = '{8'h7F, 8'h80, 9'h0FF, 9'h1FF, 9'h0FF};
    tbl[8] = '{8'h0F, 8'h01, 9'h010, 9'h010, 9'h010};
    tbl[9] = '{8'hF0, 8'h10, 9'h100, 9'h000, 9'h100};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = 8'h00; b3 = 8'h00;
    tick(); tick();
    reset = 1'b0;
    chk("reset in_ready", rdy0, 1);
    chk("reset out_valid", ov0, 0);
    chk("reset y", y0, 0);
    chk("reset in_ready w", rdy3, 1);
    chk("reset y w", y3, 0);

    for (int i = 0; i < 10; i++) op3(tbl[i].a, tbl[i].b, tbl[i].eu, tbl[i].es, tbl[i].em, "vec");

    // Backpressure: result held while the consumer stalls, new operands ignored.
    a = 8'h3C; b = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("bp", 3);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hAA; b = 8'($urandom);
      tick();
      chk("bp out_valid", ov0, 1);
      chk("bp y stable", y0, 9'h041);
      chk("bp in_ready", rdy0, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release ov", ov0, 0);
    chk("bp release rdy", rdy0, 1);
    chk("bp release y", y0, 9'h041);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp no ghost op", ov0, 0);
    end

    // Reset after one chunk of a run aborts it and clears y.
    a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst run rdy", rdy0, 1);
    chk("rst run ov", ov0, 0);
    chk("rst run y", y0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst run no result", ov0, 0);
    end
    op3(8'h10, 8'h20, 9'h030, 9'h030, 9'h030, "after rst");

    // Reset wins over a simultaneous accept.
    reset = 1'b1; in_valid = 1'b1; a = 8'h55; b = 8'h11;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst prec rdy", rdy0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst prec no result", ov0, 0);
    end

    // Single-chunk configuration: latency of one edge, result truncated to 4 bits.
    a3 = 8'hFF; b3 = 8'h02; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    lat = 0;
    while (!ov3 && lat < 20) begin
      tick();
      lat++;
    end
    chk("w latency", lat, 1);
    chk("w y", y3, 4'h1);
    out_ready3 = 1'b1;
    tick();
    chk("w release ov", ov3, 0);

    // Random back-to-back streams on both chunk configurations.
    cyc = 0; last0 = -1; last3 = -1; nres0 = 0; nres3 = 0;
    in_valid = 1'b1; out_ready = 1'b1; in_valid3 = 1'b1; out_ready3 = 1'b1;
    repeat (400) begin
      if (ov0) begin
        if (q012.size() == 0) begin
          chk("rnd unexpected result", 0, 1);
        end else begin
          e = q012.pop_front();
          chk("rnd y unsigned", y0, e.eu);
          chk("rnd y signed", y1, e.es);
          chk("rnd y mixed", y2, e.em);
        end
        if (last0 >= 0) chk("rnd period", cyc - last0, 5);
        last0 = cyc;
        nres0++;
      end
      if (rdy0) begin
        a = 8'($urandom); b = 8'($urandom);
        e.eu = ref9(a, b, 1'b0);
        e.es = ref9(a, b, 1'b1);
        e.em = ref9(a, b, 1'b0);
        q012.push_back(e);
      end
      if (ov3) begin
        if (q3.size() == 0) chk("rnd w unexpected result", 0, 1);
        else chk("rnd w y", y3, q3.pop_front());
        if (last3 >= 0) chk("rnd w period", cyc - last3, 3);
        last3 = cyc;
        nres3++;
      end
      if (rdy3) begin
        a3 = 8'($urandom); b3 = 8'($urandom);
        q3.push_back(ref4(a3, b3));
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; in_valid3 = 1'b0;
    chk("rnd result count", 32'(nres0 >= 75), 1);
    chk("rnd w result count", 32'(nres3 >= 125), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
